// File: rtl/piso_pkg.sv
// Shared definitions for the serial shift-register link (transmitter, receiver, benches).
package piso_pkg;

  // Default word length used across the link.
  localparam int unsigned PISO_WIDTH = 6;

  // Transmitter FSM states; encodings are shared with the receiver side.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/piso_shreg.sv
// Loadable shift register: parallel load has priority over shift, vacated bits fill with 0.
module piso_shreg
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             sout
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next register contents: load a fresh word, or move one bit toward the serial output.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = d;
    end else if (shift) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
    end
  end

  // Register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // The serial bit is taken straight from a flop, so the output is registered.
  assign sout = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word load, one bit per clock on dout,
// back-to-back frames when a new word is offered on the last bit of the current one.
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = PISO_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned     CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  piso_state_e      state_q;
  piso_state_e      state_d;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] bit_cnt_d;

  logic on_last;
  logic load;
  logic shift;

  // Handshake is derived from state only, never from load_valid.
  assign on_last    = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_CNT);
  assign load_ready = (state_q == ST_IDLE) || on_last;
  assign load       = load_valid && load_ready;

  // A load on the last bit replaces the shift; after the final shift of a frame the
  // register has been emptied by zero fill, which keeps dout at 0 in IDLE.
  assign shift = (state_q == ST_SHIFT) && !load;

  piso_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .d    (load_data),
    .sout (dout)
  );

  // Next-state and bit counter: start a frame on load, count bits, chain or return to IDLE.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        if (on_last) begin
          bit_cnt_d = '0;
          state_d   = load ? ST_SHIFT : ST_IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // State and counter registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign dout_valid = (state_q == ST_SHIFT);
  assign busy       = (state_q == ST_SHIFT);
  assign frame_done = on_last;

endmodule
